dogm240_spi_rx: RTL and testbench
=================================

Name: dogm240_spi_rx

Overview:
- Display-side receiver for the serial stream that the DOGM240 display driver emits on CS_n/SCK/SDA/CD/RES_n.
- Deserializes bytes, decodes a fixed command subset, tracks column and page addresses, and emits framebuffer write strobes.
- Used as a synthesizable bus-functional display model in system benches, and as a loopback checker on the FPGA beside the driver.

Parameters:
- COLS, 240, number of columns; the column address wraps at COLS-1.
- PAGES, 16, number of 8-row pages; the page address wraps at PAGES-1.

Ports:
- clk_in  input  1  system clock; must be at least 4x the SCK frequency.
- reset_in  input  1  asynchronous, active-low reset.
- disp_cs_n_i  input  1  chip select, active low, asynchronous to clk_in.
- disp_res_n_i  input  1  display reset, active low, asynchronous.
- disp_sck_i  input  1  serial clock; data is sampled on the rising edge.
- disp_data_i  input  1  serial data, MSB first.
- disp_addr_i  input  1  CD line; 0 = command, 1 = data; sampled with bit 0 (the 8th bit).
- fb_addr_o  output  12  framebuffer address {page[3:0], col[7:0]}.
- fb_data_o  output  8  data byte.
- fb_we_o  output  1  one-cycle write strobe.
- cmd_o  output  8  last command byte.
- cmd_valid_o  output  1  one-cycle strobe, any command byte.
- disp_on_o  output  1  display enable state.
- frame_err_o  output  1  sticky: CS_n rose mid-byte.

Behaviour:
- Reset values (reset_in low): all outputs 0; col=0, page=0; state IDLE; bit counter 0.
- Input synchronization:
  - All five display inputs pass through 2-flop synchronizers.
  - A SCK rising edge is sync2=1 while sync3=0.
  - Shift register and counter update in that cycle.
- Latency: fb_we_o or cmd_valid_o asserts exactly 4 clk_in cycles after the pin-level 8th SCK rising edge.
- FSM IDLE:
  - Synced CS_n low -> SHIFT with bit counter 0.
  - SCK edges seen while in IDLE are ignored.
- FSM SHIFT:
  - Each SCK edge: shift in SDA and increment the counter.
  - When the counter reaches 8: latch CD, go to DECODE, counter reset to 0.
  - Synced CS_n high -> IDLE. If counter != 0, frame_err_o := 1 and the partial byte is discarded.
- FSM DECODE (one cycle), then back to SHIFT (or IDLE if CS_n is high).
  - CD=1 (data):
    - fb_addr_o={page,col}, fb_data_o=byte, fb_we_o=1.
    - Then col+1. If col==COLS-1: col=0 and page+1. If page==PAGES-1, page wraps to 0.
  - CD=0 (command): cmd_o=byte, cmd_valid_o=1, then:
    - 0x00-0x0F: col[3:0]=byte[3:0].
    - 0x10-0x1F: col[7:4]=byte[3:0].
    - 0x60-0x6F: page=byte[3:0].
    - 0xAF: disp_on_o=1. 0xAE: disp_on_o=0.
    - 0xE2: col=0, page=0, disp_on_o=0.
    - Any other byte: cmd_valid_o only, no state change.
- Column set out of range (col >= COLS): the value is stored as is. The next data write uses it, then wraps to col=0 and page+1.
- Back-to-back bytes with CS_n held low: supported. DECODE occupies one cycle, which the 4x clock ratio guarantees fits between SCK edges.
- Synced disp_res_n_i low (at any time, including mid-byte):
  - Same effect as 0xE2.
  - Also clears the counter and the shift register, and forces IDLE.
  - No strobes are generated and frame_err_o is not set.
  - frame_err_o clears only on reset_in.
- reset_in asserted mid-byte: immediate return to reset values; the partial byte is lost.

Optional Feature:
- Macro: DOGM240_SPI_RX_MIRROR_EN.
- Defined:
  - Adds an internal COLS*PAGES x 8 framebuffer RAM written by fb_we_o.
  - Adds ports rd_addr_i (12) and rd_data_o (8).
  - rd_data_o is registered, 1-cycle read latency.
  - A read of the address being written in the same cycle returns the old data.
- Not defined: no RAM and no rd_* ports; the strobe outputs are unchanged.

Test Plan:
- Command 0x05, then 0x13 (CD=0), then data 0xA5 (CD=1) -> cmd_valid_o twice; fb_we_o with fb_addr_o=0x035, fb_data_o=0xA5, asserted exactly 4 cycles after the 8th SCK edge.
- Page 0x67, col set to 239 (0x0F, 0x1E), 2 data bytes -> writes at {7,239} then {8,0}; from page 15, col 239 -> next write goes to {0,0}.
- 16 data bytes streamed with CS_n held low, SCK = clk/4 -> 16 strobes, no frame_err_o, addresses col 0..15 contiguous.
- CS_n raised after 5 bits -> frame_err_o=1, no strobe; the following full byte decodes normally; frame_err_o stays 1 until reset_in.
- 0xAF -> disp_on_o=1; disp_res_n_i pulsed low mid-byte -> disp_on_o=0, col=page=0, no strobe, frame_err_o unchanged.
- MIRROR_EN: write 0x3C at {2,100}, read rd_addr_i=0x264 -> rd_data_o=0x3C one cycle later.

Source files
------------

// File: rtl/dogm240_spi_rx.sv
// dogm240_spi_rx
//   Display-side receiver for the DOGM240 serial stream (CS_n/SCK/SDA/CD/RES_n).
//   Deserializes bytes MSB first and decodes the column, page, display on/off
//   and soft-reset commands. It tracks the column/page address and emits one
//   framebuffer write strobe per data byte.
//
//   Optional: `define DOGM240_SPI_RX_MIRROR_EN adds an internal COLS*PAGES x 8
//   framebuffer RAM, written by fb_we_o and read through rd_addr_i/rd_data_o.
//   The read port is registered (1-cycle latency). A read of the address being
//   written in the same cycle returns the old data.
//
// Ports
//   clk_in       system clock, must be >= 4x SCK
//   reset_in     async active-low reset
//   disp_*_i     raw display pins (asynchronous, synchronized inside)
//   fb_addr_o    {page[3:0], col[7:0]} of the data byte being written
//   fb_data_o    data byte
//   fb_we_o      one-cycle write strobe
//   cmd_o        last command byte
//   cmd_valid_o  one-cycle strobe per command byte
//   disp_on_o    display enable state
//   frame_err_o  sticky, set when CS_n rises mid-byte
//   rd_addr_i    (mirror only) read address {page, col}
//   rd_data_o    (mirror only) registered read data
module dogm240_spi_rx #(
  parameter int unsigned COLS  = 240,
  parameter int unsigned PAGES = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        disp_cs_n_i,
  input  logic        disp_res_n_i,
  input  logic        disp_sck_i,
  input  logic        disp_data_i,
  input  logic        disp_addr_i,
`ifdef DOGM240_SPI_RX_MIRROR_EN
  input  logic [11:0] rd_addr_i,
  output logic [7:0]  rd_data_o,
`endif
  output logic [11:0] fb_addr_o,
  output logic [7:0]  fb_data_o,
  output logic        fb_we_o,
  output logic [7:0]  cmd_o,
  output logic        cmd_valid_o,
  output logic        disp_on_o,
  output logic        frame_err_o
);

  localparam logic [7:0] COL_LAST  = 8'(COLS - 1);
  localparam logic [3:0] PAGE_LAST = 4'(PAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_sck_s;
  logic [1:0]  r_cs_s, r_res_s, r_sda_s, r_cd_s;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_cd;
  logic [7:0]  r_col;
  logic [3:0]  r_page;

  logic w_sck_rise, w_cs_n, w_res_n;

  // The third SCK stage exists only for edge detection. All other pins are
  // taken from the second stage so that they line up with the detected edge.
  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_cs_n     = r_cs_s[1];
  assign w_res_n    = r_res_s[1];

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_sck_s <= '0;
      r_cs_s  <= 2'b11;
      r_res_s <= 2'b11;
      r_sda_s <= '0;
      r_cd_s  <= '0;
    end else begin
      r_sck_s <= {r_sck_s[1:0], disp_sck_i};
      r_cs_s  <= {r_cs_s[0], disp_cs_n_i};
      r_res_s <= {r_res_s[0], disp_res_n_i};
      r_sda_s <= {r_sda_s[0], disp_data_i};
      r_cd_s  <= {r_cd_s[0], disp_addr_i};
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_cs_n) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (w_cs_n) w_state_nxt = S_IDLE;
                else if (w_sck_rise && r_bit_cnt == 4'd7) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_cs_n ? S_IDLE : S_SHIFT;
      default:  w_state_nxt = S_IDLE;
    endcase
    // A display reset holds the receiver idle for as long as it is asserted.
    if (!w_res_n) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_cd        <= 1'b0;
      r_col       <= '0;
      r_page      <= '0;
      fb_addr_o   <= '0;
      fb_data_o   <= '0;
      fb_we_o     <= 1'b0;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      disp_on_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      fb_we_o     <= 1'b0;
      cmd_valid_o <= 1'b0;
      if (!w_res_n) begin
        // Same as 0xE2, plus the partial byte is dropped silently.
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_col     <= '0;
        r_page    <= '0;
        disp_on_o <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_bit_cnt <= '0;
          S_SHIFT: begin
            if (w_cs_n) begin
              if (r_bit_cnt != 4'd0) frame_err_o <= 1'b1;
              r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
              r_shift <= {r_shift[6:0], r_sda_s[1]};
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                r_cd      <= r_cd_s[1];
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_DECODE: begin
            if (r_cd) begin
              fb_addr_o <= {r_page, r_col};
              fb_data_o <= r_shift;
              fb_we_o   <= 1'b1;
              // '>=' so that an out-of-range column also wraps after one write.
              if (r_col >= COL_LAST) begin
                r_col  <= '0;
                r_page <= (r_page == PAGE_LAST) ? 4'd0 : r_page + 4'd1;
              end else begin
                r_col <= r_col + 8'd1;
              end
            end else begin
              cmd_o       <= r_shift;
              cmd_valid_o <= 1'b1;
              case (r_shift[7:4])
                4'h0:    r_col[3:0] <= r_shift[3:0];
                4'h1:    r_col[7:4] <= r_shift[3:0];
                4'h6:    r_page     <= r_shift[3:0];
                default: begin
                  case (r_shift)
                    8'hAF: disp_on_o <= 1'b1;
                    8'hAE: disp_on_o <= 1'b0;
                    8'hE2: begin
                      r_col     <= '0;
                      r_page    <= '0;
                      disp_on_o <= 1'b0;
                    end
                    default: ;
                  endcase
                end
              endcase
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

`ifdef DOGM240_SPI_RX_MIRROR_EN
  localparam int unsigned DEPTH = COLS * PAGES;

  logic [7:0]  r_mem [DEPTH];
  logic [11:0] w_wr_idx, w_rd_idx;
  logic        w_wr_ok, w_rd_ok;

  // RAM is packed linearly as page*COLS + col; columns past COLS-1 have no storage.
  assign w_wr_idx = {8'd0, fb_addr_o[11:8]} * 12'(COLS) + {4'd0, fb_addr_o[7:0]};
  assign w_rd_idx = {8'd0, rd_addr_i[11:8]} * 12'(COLS) + {4'd0, rd_addr_i[7:0]};
  assign w_wr_ok  = (fb_addr_o[7:0] <= COL_LAST) && (fb_addr_o[11:8] <= PAGE_LAST);
  assign w_rd_ok  = (rd_addr_i[7:0] <= COL_LAST) && (rd_addr_i[11:8] <= PAGE_LAST);

  always_ff @(posedge clk_in) begin
    if (fb_we_o && w_wr_ok) r_mem[w_wr_idx] <= fb_data_o;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) rd_data_o <= '0;
    else           rd_data_o <= w_rd_ok ? r_mem[w_rd_idx] : 8'd0;
  end
`endif

endmodule

// File: tb/tb_dogm240_spi_rx.sv
// Testbench for dogm240_spi_rx: randomized serial stream, reference model of
// the display address/command rules, and a scoreboard checked by a monitor.
module tb_dogm240_spi_rx;
  localparam int COLS  = 240;
  localparam int PAGES = 16;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        cs_n = 1'b1, res_n = 1'b1, sck = 1'b0, sda = 1'b0, cd = 1'b0;
  logic [11:0] fb_addr_o;
  logic [7:0]  fb_data_o, cmd_o;
  logic        fb_we_o, cmd_valid_o, disp_on_o, frame_err_o;
`ifdef DOGM240_SPI_RX_MIRROR_EN
  logic [11:0] rd_addr_i = '0;
  logic [7:0]  rd_data_o;
`endif

  dogm240_spi_rx #(.COLS(COLS), .PAGES(PAGES)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .disp_cs_n_i  (cs_n),
    .disp_res_n_i (res_n),
    .disp_sck_i   (sck),
    .disp_data_i  (sda),
    .disp_addr_i  (cd),
`ifdef DOGM240_SPI_RX_MIRROR_EN
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
`endif
    .fb_addr_o    (fb_addr_o),
    .fb_data_o    (fb_data_o),
    .fb_we_o      (fb_we_o),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .disp_on_o    (disp_on_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    bit         is_cmd;
    logic [11:0] addr;
    logic [7:0]  data;
    bit         don;
    int         cyc;
  } exp_t;
  exp_t q[$];

  // Reference model state.
  int m_col = 0, m_page = 0;
  bit m_don = 0, m_ferr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Apply one complete byte to the model; the strobe is due 4 cycles after the 8th edge.
  task automatic model_byte(input logic [7:0] b, input logic c, input int edge_cyc);
    exp_t e;
    e.cyc = edge_cyc + 4;
    e.is_cmd = !c;
    e.data = b;
    e.addr = '0;
    if (c) begin
      e.addr = {4'(m_page), 8'(m_col)};
      m_col = m_col + 1;
      if (m_col >= COLS) begin
        m_col = 0;
        m_page = (m_page + 1) % PAGES;
      end
    end else begin
      if (b < 8'h10)                     m_col = (m_col & 'hF0) | int'(b & 8'h0F);
      else if (b < 8'h20)                m_col = (m_col & 'h0F) | (int'(b & 8'h0F) << 4);
      else if (b >= 8'h60 && b < 8'h70)  m_page = int'(b & 8'h0F);
      else if (b == 8'hAF)               m_don = 1;
      else if (b == 8'hAE)               m_don = 0;
      else if (b == 8'hE2) begin m_col = 0; m_page = 0; m_don = 0; end
    end
    e.don = m_don;
    q.push_back(e);
  endtask

  // One SCK period = 4 clk_in cycles: 2 low, 2 high, data changed while SCK low.
  task automatic clk_bit(input logic b);
    @(negedge clk_in); sck = 1'b0; sda = b;
    @(negedge clk_in);
    @(negedge clk_in); sck = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic c);
    for (int i = 7; i >= 1; i--) clk_bit(b[i]);
    @(negedge clk_in); sck = 1'b0; sda = b[0]; cd = c;
    @(negedge clk_in);
    @(negedge clk_in); sck = 1'b1; model_byte(b, c, cyc);
    @(negedge clk_in);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) clk_bit(1'($urandom_range(0, 1)));
    @(negedge clk_in); sck = 1'b0;
  endtask

  task automatic begin_frame();
    @(negedge clk_in); cs_n = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic end_frame();
    @(negedge clk_in); sck = 1'b0;
    repeat (3) @(negedge clk_in);
    cs_n = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  function automatic logic [7:0] rand_cmd();
    logic [7:0] r;
    case ($urandom_range(0, 6))
      0: r = {4'h0, 4'($urandom_range(0, 15))};
      1: r = {4'h1, 4'($urandom_range(0, 15))};
      2: r = {4'h6, 4'($urandom_range(0, 15))};
      3: r = 8'hAF;
      4: r = 8'hAE;
      5: r = 8'hE2;
      default: r = 8'($urandom_range(0, 255));
    endcase
    return r;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (reset_in && (fb_we_o || cmd_valid_o)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: we=%0b cmd_valid=%0b addr=0x%0h data=0x%0h cmd=0x%0h expected none",
                 fb_we_o, cmd_valid_o, fb_addr_o, fb_data_o, cmd_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_cmd_valid", 32'(cmd_valid_o), 32'(e.is_cmd));
        chk("strobe_fb_we", 32'(fb_we_o), 32'(!e.is_cmd));
        chk("strobe_latency", 32'(cyc), 32'(e.cyc));
        if (e.is_cmd) chk("cmd_byte", 32'(cmd_o), 32'(e.data));
        else begin
          chk("fb_addr", 32'(fb_addr_o), 32'(e.addr));
          chk("fb_data", 32'(fb_data_o), 32'(e.data));
        end
        chk("disp_on_at_strobe", 32'(disp_on_o), 32'(e.don));
      end
    end
  end

  initial begin
    logic [7:0] b;
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_fb_addr", 32'(fb_addr_o), 0);
    chk("rst_fb_data", 32'(fb_data_o), 0);
    chk("rst_fb_we", 32'(fb_we_o), 0);
    chk("rst_cmd", 32'(cmd_o), 0);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
    chk("rst_disp_on", 32'(disp_on_o), 0);
    chk("rst_frame_err", 32'(frame_err_o), 0);
    @(negedge clk_in); reset_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // Column set low/high nibble then one data byte at {0, 0x35}
    begin_frame();
    send_byte(8'h05, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'hA5, 1'b1);

    // Column wrap from 239 into the next page, then page 15 wrap to {0,0}
    send_byte(8'h67, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h1E, 1'b0);
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);
    send_byte(8'h6F, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h1E, 1'b0);
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);

    // Out-of-range column 255 is used once, then wraps
    send_byte(8'h63, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h1F, 1'b0);
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);

    // 16 back-to-back data bytes from column 0
    send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
    send_byte({4'h6, 4'($urandom_range(0, 15))}, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    end_frame();
    chk("no_frame_err_stream", 32'(frame_err_o), 0);

    // CS_n raised after 5 bits
    begin_frame();
    send_bits(5);
    end_frame();
    m_ferr = 1;
    chk("frame_err_set", 32'(frame_err_o), 32'(m_ferr));
    begin_frame();
    send_byte(8'($urandom), 1'b1);
    repeat (6) @(negedge clk_in);
    chk("frame_err_sticky", 32'(frame_err_o), 32'(m_ferr));

    // Display on, then display reset mid-byte
    send_byte(8'hAF, 1'b0);
    repeat (6) @(negedge clk_in);
    chk("disp_on_af", 32'(disp_on_o), 1);
    send_bits(3);
    @(negedge clk_in); res_n = 1'b0;
    repeat (4) @(negedge clk_in);
    res_n = 1'b1;
    m_col = 0; m_page = 0; m_don = 0;
    repeat (6) @(negedge clk_in);
    chk("disp_on_after_res", 32'(disp_on_o), 0);
    chk("frame_err_after_res", 32'(frame_err_o), 32'(m_ferr));
    send_byte(8'($urandom), 1'b1);

`ifdef DOGM240_SPI_RX_MIRROR_EN
    send_byte(8'h62, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h16, 1'b0);
    send_byte(8'h3C, 1'b1);
    repeat (8) @(negedge clk_in);
    rd_addr_i = 12'h264;
    @(negedge clk_in);
    chk("mirror_read", 32'(rd_data_o), 32'h3C);
`endif

    // Random mix of commands and data
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) b = rand_cmd();
      else b = 8'($urandom);
      send_byte(b, (b == 8'h00) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    end_frame();

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk_in);
    chk("queue_drained", 32'(q.size()), 0);
    chk("frame_err_final", 32'(frame_err_o), 32'(m_ferr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
